// File: rtl/vs_ram_reader_pkg.sv
// Shared types and sizing for the synchronous-RAM stream reader.
package vs_ram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int READER_FIFO_DEPTH = 4;

endpackage

// File: rtl/vs_small_sync_fifo.sv
// Small single-clock FIFO with synchronous reset and an occupancy output.
module vs_small_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full      = (occ_q == OCC_W'(DEPTH));
    assign empty     = (occ_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/vs_sync_ram_stream_reader.sv
// Streams a block of consecutive RAM words onto a valid/ready interface,
// hiding the RAM's one-cycle read latency behind a small skid buffer.
//
// state | meaning
// IDLE  | waiting for start; zero-length start only pulses done
// RUN   | issuing reads while occupancy plus in-flight read is below depth
// DRAIN | all reads issued; waiting for in-flight word and buffer to empty
module vs_sync_ram_stream_reader
    import vs_ram_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int OCC_W = $clog2(READER_FIFO_DEPTH + 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  v1_q;
    logic                  last1_q;
    logic                  done_q;
    logic                  done_d;

    logic [OCC_W-1:0]      occ;
    logic [OCC_W:0]        load;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  issue;
    logic                  issue_last;
    logic                  pop;
    logic                  launch;

    // Counting the in-flight read against the depth is what keeps the buffer from overflowing.
    assign load       = {1'b0, occ} + {{OCC_W{1'b0}}, v1_q};
    assign issue      = (state_q == RUN) && (load < (OCC_W + 1)'(READER_FIFO_DEPTH));
    assign issue_last = (rem_q == LEN_WIDTH'(1));
    assign pop        = out_valid && out_ready;
    assign launch     = (state_q == IDLE) && start && (length != '0);

    vs_small_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (READER_FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (v1_q),
        .push_data ({last1_q, ram_read_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .occ       (occ),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) state_d = RUN;
                    else              done_d  = 1'b1;
                end
            end
            RUN: begin
                if (issue && issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave on the final pop so busy drops the cycle after the last handshake.
                if (!v1_q && ((occ == '0) || ((occ == OCC_W'(1)) && pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            v1_q    <= issue;
            last1_q <= issue && issue_last;
            if (launch) begin
                addr_q <= base_addr;
                rem_q  <= length;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                rem_q  <= rem_q - LEN_WIDTH'(1);
            end
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign ram_read_addr = addr_q;
    assign out_valid     = !fifo_empty;
    assign out_data      = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
    assign out_last      = !fifo_empty && fifo_head[DATA_WIDTH];

endmodule

// File: doc/vs_sync_ram_stream_reader.md
# vs_sync_ram_stream_reader

Read-side controller for the single-clock synchronous RAM. On a start command it streams `length` consecutive words, beginning at `base_addr`, out of the RAM onto a valid/ready stream, and hides the RAM's one-cycle read latency. A small buffer absorbs downstream backpressure without losing or duplicating words. It sits between the RAM read port and any consumer of memory contents, such as a DMA path or a sparse-vector engine.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 16, RAM address width
- `LEN_WIDTH`, `ADDR_WIDTH+1`, width of `length`, wide enough to cover the full 2**ADDR_WIDTH memory

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock; all state updates on posedge
- `reset` in 1: synchronous, active-high
- `start` in 1: command strobe, sampled only in IDLE
- `base_addr` in ADDR_WIDTH: first address, sampled with `start`
- `length` in LEN_WIDTH: word count, sampled with `start`
- `busy` out 1: transfer in progress
- `done` out 1: one-cycle completion pulse
- `ram_read_addr` out ADDR_WIDTH: registered address to the RAM read port
- `ram_read_data` in DATA_WIDTH: RAM output, valid one cycle after its address was presented
- `out_data` out DATA_WIDTH: stream data
- `out_valid` out 1: stream valid
- `out_ready` in 1: stream ready
- `out_last` out 1: marks the final word of a transfer

## Operation
- FSM states:
  - IDLE: `start` with length≠0 goes to RUN, latching address and remaining count. `start` with length=0 stays in IDLE and pulses `done` in the next cycle.
  - RUN: issue reads until all `length` reads have been issued, then go to DRAIN.
  - DRAIN: wait until the in-flight stage and the buffer are both empty, then go to IDLE and pulse `done`.
- Issue rule: a read is issued in a cycle iff state is RUN and `occ + v1 < 4`.
  - `occ` is the buffer occupancy.
  - `v1` is the registered flag "read issued last cycle".
  - An issue presents `ram_read_addr` this cycle; the address register then increments modulo 2**ADDR_WIDTH.
- Data capture: when `v1` = 1, `ram_read_data` is pushed into the buffer at the clock edge ending that cycle.
- Output: `out_valid` = buffer non-empty, `out_data` = buffer head. A pop occurs on `out_valid && out_ready`.
- `out_last` is asserted with the word whose index is length−1; a per-word last flag is carried through the buffer.
- `start` while `busy` is ignored; no queueing.
- If a RAM write targets the address being read in the same cycle, old data is returned, which is the RAM's defined behaviour. The reader does not compensate.
- Buffer depth 4 guarantees no overflow: occ + v1 never exceeds 4.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `ram_read_addr`=0, state IDLE, buffer empty, `v1`=0.
- Reset mid-transfer aborts immediately: buffered and in-flight data are discarded, no `done` is pulsed, and all outputs take their reset values in the next cycle.
- Cycle numbering: cycle 0 is the cycle in which `start` is high.
  - Cycle 1: `busy`=1 and `ram_read_addr`=`base_addr` (first issue).
  - Cycle 2: RAM data present.
  - Cycle 3: `out_valid`=1 with mem[base].
  - Latency from `start` to first `out_valid` is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle with no bubbles.
- `busy` stays high through the cycle of the final handshake. The following cycle has `busy`=0 and `done`=1.
- Wrap-around: the address after 2**ADDR_WIDTH−1 is 0. `length` = 2**ADDR_WIDTH reads the whole memory exactly once.
- Simultaneous push and pop in one cycle leaves `occ` unchanged.

## Structure
- Package `vs_ram_reader_pkg` contains:
  - `state_t` enum {IDLE, RUN, DRAIN}
  - `READER_FIFO_DEPTH` = 4
- One sub-module, `vs_small_sync_fifo`:
  - Parameterised width/depth, synchronous reset.
  - Exposes `occ`; holds {last, data} entries.
- Issue logic, counters and the FSM live in the top module.

## Test plan
- Preload mem[0x10..0x13]=A0,A1,A2,A3; start base=0x10 len=4, `out_ready`=1 → A0..A3 valid in cycles 3–6; `out_last` only with A3; `done` in cycle 7.
- Same setup with `out_ready` low for cycles 3–9 → `ram_read_addr` stops advancing once occ+v1=4; after release, A0..A3 delivered in order with no loss or duplication.
- ADDR_WIDTH=4, base=0xE, len=4 → reads at 0xE,0xF,0x0,0x1; `out_last` on the fourth word.
- len=0 → `done` pulse in cycle 1; `busy` and `out_valid` never assert.
- Start len=8 with `out_ready`=0, assert `reset` in cycle 5 → all outputs at reset values in cycle 6; a new start of len=2 then completes normally.
- Second `start` during a transfer → ignored; word count and `done` count match the first command only.
